// File: rtl/dmem_responder_if.sv
// Core <-> data-memory valid/yumi load/store handshake bundle.
// The master modport is the core side and the slave modport is the memory side.
interface dmem_responder_if;
    logic        valid_i;
    logic        wen_i;
    logic        byte_not_word_i;
    logic [31:0] addr_i;
    logic [31:0] write_data_i;
    logic        yumi_i;
    logic        yumi_o;
    logic        valid_o;
    logic [31:0] read_data_o;
    logic        err_o;

    modport master (
        output valid_i, wen_i, byte_not_word_i, addr_i, write_data_i, yumi_i,
        input  yumi_o, valid_o, read_data_o, err_o
    );

    modport slave (
        input  valid_i, wen_i, byte_not_word_i, addr_i, write_data_i, yumi_i,
        output yumi_o, valid_o, read_data_o, err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised, byte-addressable RAM behind a valid/yumi handshake
// with programmable response latency. Optional access counters: define DMEM_ACCESS_COUNT_EN.
module dmem_responder #(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic              clk,
    input  logic              n_reset,
    dmem_responder_if.slave   bus
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [15:0]       load_count_o,
    output logic [15:0]       store_count_o
`endif
);

    localparam int          WORDS    = 1 << addr_width_p;
    localparam bit          LAT_ZERO = (latency_p == 0);
    localparam logic [3:0]  LAT_M1   = LAT_ZERO ? 4'd0 : 4'(latency_p - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [3:0]                cnt_r;
    logic [3:0]                cnt_s;
    logic                      valid_r;
    logic                      yumi_s;
    logic                      accept_s;
    logic [31:0]               read_data_r;
    logic                      err_r;
    logic [31:0]               mem_r [WORDS];
    logic [addr_width_p-1:0]   word_idx_s;
    logic [1:0]                lane_s;
    logic                      in_range_s;
    logic [31:0]               rd_word_s;
    logic [31:0]               load_data_s;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign word_idx_s = bus.addr_i[addr_width_p+1:2];
    assign lane_s     = bus.addr_i[1:0];
    assign in_range_s = ~|bus.addr_i[31:addr_width_p+2];
    assign rd_word_s  = mem_r[word_idx_s];
    assign accept_s   = (state_r == ST_IDLE) && bus.valid_i;

    assign bus.yumi_o      = yumi_s;
    assign bus.valid_o     = valid_r;
    assign bus.read_data_o = read_data_r;
    assign bus.err_o       = err_r;

    // Load result as it will be presented: zero for stores and out-of-range, byte loads zero-extended.
    always_comb begin
        load_data_s = 32'h0000_0000;
        if (bus.wen_i || !in_range_s) begin
            load_data_s = 32'h0000_0000;
        end else if (bus.byte_not_word_i) begin
            load_data_s = {24'h00_0000, byte_sel(rd_word_s, lane_s)};
        end else begin
            load_data_s = rd_word_s;
        end
    end

    // Handshake state machine: next state, latency counter and request acknowledge.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        yumi_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                yumi_s = bus.valid_i;
                if (bus.valid_i) begin
                    if (LAT_ZERO) begin
                        state_s = ST_RESP;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = LAT_M1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                if (bus.yumi_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State, counter and registered response-valid.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            valid_r <= (state_s == ST_RESP);
        end
    end

    // Response data and sticky range error, both captured on the acceptance edge.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            read_data_r <= 32'h0000_0000;
            err_r       <= 1'b0;
        end else if (accept_s) begin
            read_data_r <= load_data_s;
            err_r       <= err_r | ~in_range_s;
        end
    end

    // RAM array is deliberately not reset; stores commit on acceptance so a later reset keeps them.
    always_ff @(posedge clk) begin
        if (accept_s && bus.wen_i && in_range_s) begin
            if (bus.byte_not_word_i) begin
                case (lane_s)
                    2'd0:    mem_r[word_idx_s][7:0]   <= bus.write_data_i[7:0];
                    2'd1:    mem_r[word_idx_s][15:8]  <= bus.write_data_i[7:0];
                    2'd2:    mem_r[word_idx_s][23:16] <= bus.write_data_i[7:0];
                    2'd3:    mem_r[word_idx_s][31:24] <= bus.write_data_i[7:0];
                    default: mem_r[word_idx_s]        <= mem_r[word_idx_s];
                endcase
            end else begin
                mem_r[word_idx_s] <= bus.write_data_i;
            end
        end
    end

`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] load_count_r;
    logic [15:0] store_count_r;

    assign load_count_o  = load_count_r;
    assign store_count_o = store_count_r;

    // Saturating per-type access counters, out-of-range accesses included.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            load_count_r  <= 16'h0000;
            store_count_r <= 16'h0000;
        end else if (accept_s) begin
            if (bus.wen_i && (store_count_r != 16'hFFFF)) begin
                store_count_r <= store_count_r + 16'd1;
            end else if (!bus.wen_i && (load_count_r != 16'hFFFF)) begin
                load_count_r <= load_count_r + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a latency-2 instance driven by a request task with a
// queue-based response monitor, plus a latency-0 instance for back-to-back handshakes.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic n_reset;
    int   checks = 0;
    int   passed = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

`ifdef DMEM_ACCESS_COUNT_EN
    logic [15:0] lc, sc, lc0, sc0;
`endif

    dmem_responder #(.addr_width_p(10), .latency_p(LAT)) dut (
        .clk(clk), .n_reset(n_reset), .bus(bus)
`ifdef DMEM_ACCESS_COUNT_EN
        , .load_count_o(lc), .store_count_o(sc)
`endif
    );

    dmem_responder #(.addr_width_p(10), .latency_p(0)) dut0 (
        .clk(clk), .n_reset(n_reset), .bus(bus0)
`ifdef DMEM_ACCESS_COUNT_EN
        , .load_count_o(lc0), .store_count_o(sc0)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: one pop per response, compared on every cycle valid_o is high.
    initial begin
        logic        have;
        logic [31:0] cur;
        have = 1'b0;
        cur  = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.valid_o === 1'b1) begin
                if (!have) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL sb_unexpected_response: got %h expected none", bus.read_data_o);
                    end else begin
                        cur  = exp_q.pop_front();
                        have = 1'b1;
                    end
                end
                if (have) check("sb_read_data", bus.read_data_o, cur);
            end else begin
                have = 1'b0;
            end
        end
    end

    task automatic req(input logic wen, input logic bnw, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] exp, input int hold);
        int n;
        @(posedge clk); #1;
        bus.valid_i = 1'b1; bus.wen_i = wen; bus.byte_not_word_i = bnw;
        bus.addr_i = addr; bus.write_data_i = data;
        #1;
        check("yumi_on_request", {31'b0, bus.yumi_o}, 32'd1);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        n = 0;
        while (bus.valid_o !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, LAT);
        repeat (hold) @(posedge clk);
        #1 bus.yumi_i = 1'b1;
        @(posedge clk); #1;
        bus.yumi_i = 1'b0;
        check("valid_drop_after_yumi", {31'b0, bus.valid_o}, 32'd0);
    endtask

    task automatic store0(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        bus0.valid_i = 1'b1; bus0.wen_i = 1'b1; bus0.byte_not_word_i = 1'b0;
        bus0.addr_i = addr; bus0.write_data_i = data;
        @(posedge clk); #1;
        bus0.valid_i = 1'b0; bus0.yumi_i = 1'b1;
        @(posedge clk); #1;
        bus0.yumi_i = 1'b0;
    endtask

    initial begin
        bus.valid_i = 1'b0; bus.wen_i = 1'b0; bus.byte_not_word_i = 1'b0;
        bus.addr_i = 32'h0; bus.write_data_i = 32'h0; bus.yumi_i = 1'b0;
        bus0.valid_i = 1'b0; bus0.wen_i = 1'b0; bus0.byte_not_word_i = 1'b0;
        bus0.addr_i = 32'h0; bus0.write_data_i = 32'h0; bus0.yumi_i = 1'b0;
        n_reset = 1'b0;
        #12;
        check("rst_valid_o", {31'b0, bus.valid_o}, 32'd0);
        check("rst_yumi_o", {31'b0, bus.yumi_o}, 32'd0);
        check("rst_read_data", bus.read_data_o, 32'h0);
        check("rst_err_o", {31'b0, bus.err_o}, 32'd0);
        @(posedge clk); #1 n_reset = 1'b1;

        // Word store then load-back.
        req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        req(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        // Byte store into a known word; only write_data[7:0] may land.
        req(1'b1, 1'b0, 32'h10, 32'h11223344, 32'h0, 0);
        req(1'b1, 1'b1, 32'h11, 32'hFFFFFFAA, 32'h0, 0);
        req(1'b0, 1'b0, 32'h13, 32'h0, 32'h1122AA44, 0);
        req(1'b0, 1'b1, 32'h13, 32'h0, 32'h00000011, 0);
        req(1'b0, 1'b1, 32'h10, 32'h0, 32'h00000044, 0);
        // Core withholds yumi_i for 5 cycles; monitor checks stability each cycle.
        req(1'b0, 1'b0, 32'h10, 32'h0, 32'h1122AA44, 5);
        // Out-of-range store aliases word 0 by index bits but must not write it.
        req(1'b1, 1'b0, 32'h0, 32'h0BADF00D, 32'h0, 0);
        check("err_before_oor", {31'b0, bus.err_o}, 32'd0);
        req(1'b1, 1'b0, 32'h00001000, 32'h5, 32'h0, 0);
        check("err_set_oor", {31'b0, bus.err_o}, 32'd1);
        req(1'b0, 1'b0, 32'h0, 32'h0, 32'h0BADF00D, 0);
        req(1'b0, 1'b0, 32'h80000004, 32'h0, 32'h0, 0);
        check("err_sticky", {31'b0, bus.err_o}, 32'd1);
`ifdef DMEM_ACCESS_COUNT_EN
        check("load_count", {16'b0, lc}, 32'd7);
        check("store_count", {16'b0, sc}, 32'd5);
`endif

        // Reset asserted while in WAIT abandons the access.
        @(posedge clk); #1;
        bus.valid_i = 1'b1; bus.wen_i = 1'b0; bus.byte_not_word_i = 1'b0; bus.addr_i = 32'h10;
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        #1 n_reset = 1'b0;
        #1;
        check("rst_wait_valid_o", {31'b0, bus.valid_o}, 32'd0);
        check("rst_wait_yumi_o", {31'b0, bus.yumi_o}, 32'd0);
        check("rst_wait_err_o", {31'b0, bus.err_o}, 32'd0);
        check("rst_wait_read_data", bus.read_data_o, 32'h0);
`ifdef DMEM_ACCESS_COUNT_EN
        check("rst_load_count", {16'b0, lc}, 32'd0);
        check("rst_store_count", {16'b0, sc}, 32'd0);
`endif
        @(posedge clk); #1 n_reset = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("no_resp_after_abort", {31'b0, bus.valid_o}, 32'd0);
        req(1'b0, 1'b0, 32'h10, 32'h0, 32'h1122AA44, 0);

        // Latency 0: back-to-back loads with valid_i held high.
        store0(32'h20, 32'hCAFEF00D);
        store0(32'h24, 32'h12345678);
        @(posedge clk); #1;
        bus0.valid_i = 1'b1; bus0.wen_i = 1'b0; bus0.byte_not_word_i = 1'b0; bus0.addr_i = 32'h20;
        #1 check("b2b_yumi1", {31'b0, bus0.yumi_o}, 32'd1);
        @(posedge clk); #1;
        check("b2b_valid1", {31'b0, bus0.valid_o}, 32'd1);
        check("b2b_data1", bus0.read_data_o, 32'hCAFEF00D);
        check("b2b_no_yumi_in_resp", {31'b0, bus0.yumi_o}, 32'd0);
        bus0.yumi_i = 1'b1; bus0.addr_i = 32'h24;
        @(posedge clk); #1;
        bus0.yumi_i = 1'b0;
        #1;
        check("b2b_gap", {31'b0, bus0.valid_o}, 32'd0);
        check("b2b_yumi2", {31'b0, bus0.yumi_o}, 32'd1);
        @(posedge clk); #1;
        bus0.valid_i = 1'b0;
        check("b2b_valid2", {31'b0, bus0.valid_o}, 32'd1);
        check("b2b_data2", bus0.read_data_o, 32'h12345678);
        bus0.yumi_i = 1'b1;
        @(posedge clk); #1;
        bus0.yumi_i = 1'b0;
        check("b2b_end_idle", {31'b0, bus0.valid_o}, 32'd0);

        repeat (2) @(posedge clk);
        check("sb_queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the core's valid/yumi load/store handshake.
- Accepts one request at a time and acknowledges it with yumi_o.
- Holds the access for a programmable latency, then presents valid_o with read_data_o until the core returns yumi_i.
- Backs a word-organised, byte-addressable RAM. Sits between the core's to_mem_o/data_mem_addr and from_mem_i.

Parameters:
addr_width_p, 10, log2 of word count; RAM is 2**addr_width_p x 32 bits
latency_p, 2, cycles between request acceptance and valid_o (0..15)

Ports:
clk  input  1  clock, all state on rising edge
n_reset  input  1  asynchronous active-low reset
valid_i  input  1  core request valid (to_mem_o.valid)
wen_i  input  1  1 = store, 0 = load (to_mem_o.wen)
byte_not_word_i  input  1  1 = byte access (to_mem_o.byte_not_word)
addr_i  input  32  byte address (data_mem_addr)
write_data_i  input  32  store data; byte stores use bits [7:0]
yumi_i  input  1  core accepts response (to_mem_o.yumi)
yumi_o  output  1  request accepted (from_mem_i.yumi)
valid_o  output  1  response ready (from_mem_i.valid)
read_data_o  output  32  load result (from_mem_i.read_data)
err_o  output  1  sticky out-of-range flag

Behaviour:
- Reset (async, n_reset=0):
  - state=IDLE; valid_o=0, yumi_o=0, read_data_o=0, err_o=0, latency counter=0.
  - RAM contents are not reset.
  - Reset mid-access abandons the access. A store already committed at acceptance stays in RAM.
- States: IDLE, WAIT, RESP.
- IDLE:
  - yumi_o = valid_i, combinational.
  - On the clock edge where valid_i=1, the request is accepted: wen, byte_not_word, addr and data are captured.
  - If latency_p=0, next state is RESP. Otherwise next state is WAIT with counter=latency_p-1.
- WAIT:
  - yumi_o=0 and valid_o=0.
  - Counter decrements each cycle; at 0, next state is RESP.
- RESP:
  - valid_o=1; read_data_o is held stable.
  - On yumi_i=1, next state is IDLE and valid_o drops on the following cycle.
  - valid_o stays high for any number of cycles until yumi_i. yumi_i outside RESP is ignored.
- Latency: acceptance at edge T, valid_o high from cycle T+1+latency_p.
- Addressing:
  - Word index = addr_i[addr_width_p+1:2]; byte lane = addr_i[1:0]; little-endian (lane 0 = bits [7:0]).
  - Word accesses ignore addr_i[1:0].
- Commit: the RAM access occurs on the acceptance edge.
  - Store word: writes all 32 bits.
  - Store byte: writes only the selected lane with write_data_i[7:0].
  - Load: read data is captured at acceptance. Byte loads are zero-extended to 32 bits.
  - Stores return read_data_o=0.
- Out of range (any addr_i[31:addr_width_p+2] nonzero):
  - A store does not modify RAM; a load returns 0.
  - err_o is set and stays 1 until reset.
  - The handshake completes normally.
- Simultaneous events:
  - yumi_i in RESP together with a new valid_i: the new request is not accepted that cycle (yumi_o=0 outside IDLE). It is accepted in the next IDLE cycle, so there is a minimum one-cycle bubble.
  - valid_i held high while not in IDLE is tolerated; inputs are not sampled.
- Read-after-write: a load accepted immediately after a store completes sees the stored data.

Optional Feature:
DMEM_ACCESS_COUNT_EN
- Defined:
  - Adds outputs load_count_o[15:0] and store_count_o[15:0], reset to 0.
  - Each increments by 1 on every accepted load/store, including out-of-range ones, and saturates at 16'hFFFF.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- latency_p=2; store word addr 0x10, data 0xDEADBEEF; then load word 0x10 -> yumi_o on request cycle, valid_o 3 cycles later; load returns 0xDEADBEEF.
- Store byte 0xAA to 0x11 over word 0x11223344 -> word reads 0x1122AA44; load byte 0x13 -> 0x00000011.
- Core withholds yumi_i 5 cycles in RESP -> valid_o and read_data_o stable all 5 cycles; IDLE one cycle after yumi_i.
- latency_p=0, back-to-back loads with valid_i held high -> second yumi_o exactly one cycle after first yumi_i; valid_o gaps of one cycle.
- addr 0x0000_1000 with addr_width_p=10 store 0x5 -> RAM unchanged, err_o=1 and sticky, handshake completes.
- Assert n_reset=0 in WAIT -> valid_o/yumi_o 0 immediately, state IDLE; next request served normally; with DMEM_ACCESS_COUNT_EN the counts are 0 after reset.
